// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared constants for the two-port RAM arbiter
package ram_arbiter_pkg;

   localparam int DATA_W = 32;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Port identifiers, also used as bit index into the grant vector
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - fetch, data and RAM-side signal bundle for the arbiter
interface ram_arbiter_if #(
   parameter int DEPTH = 10
);
   import ram_arbiter_pkg::*;

   // instruction-fetch port
   logic              if_req;
   logic [DEPTH-1:0]  if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   // data port
   logic              d_req;
   logic              d_we;
   logic [DEPTH-1:0]  d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   // RAM side
   logic              ram_we;
   logic [DEPTH-1:0]  ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // arbiter view
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             ram_we, ram_addr, ram_wdata
   );

   // requester and RAM view
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - two-input round-robin grant with last-grant memory
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   import ram_arbiter_pkg::*;

   logic last_grant_q, last_grant_d;

   // grant a lone requester; on a tie favour the port that did not win last
   always_comb begin
      gnt          = 2'b00;
      last_grant_d = last_grant_q;
      if (en) begin
         if (req == 2'b11) begin
            gnt = (last_grant_q == PORT_D) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
         if (gnt != 2'b00) begin
            last_grant_d = gnt[PORT_D];
         end
      end
   end

   // last winner starts as the data port so fetch wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= PORT_D;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - fetch/data port arbiter in front of a single-port RAM
module ram_arbiter #(
   parameter int DEPTH = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   ram_arbiter_if.slave bus,
   output logic         busy
);
   import ram_arbiter_pkg::*;

   logic [1:0]        state_q, state_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [DEPTH-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic [1:0]        gnt;
   logic              arb_en;
   logic              resp_if, resp_d;
   logic [DATA_W-1:0] resp_rdata;

   // grants only in IDLE and never while reset is held
   assign arb_en = rst_n && (state_q == ST_IDLE);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arb_en),
      .req   ({bus.d_req, bus.if_req}),
      .gnt   (gnt)
   );

   assign bus.if_gnt = gnt[PORT_IF];
   assign bus.d_gnt  = gnt[PORT_D];

   assign resp_if    = (state_q == ST_RESP) && (port_q == PORT_IF);
   assign resp_d     = (state_q == ST_RESP) && (port_q == PORT_D);
   assign resp_rdata = we_q ? '0 : bus.ram_rdata;

   // rdata follows the RAM during the response cycle, then holds
   assign bus.if_rvalid = resp_if;
   assign bus.d_rvalid  = resp_d;
   assign bus.if_rdata  = resp_if ? resp_rdata : if_rdata_q;
   assign bus.d_rdata   = resp_d  ? resp_rdata : d_rdata_q;

   assign bus.ram_we    = (state_q == ST_ACCESS) && we_q;
   assign bus.ram_addr  = addr_q;
   assign bus.ram_wdata = wdata_q;

   assign busy = (state_q != ST_IDLE);

   // sequence IDLE -> ACCESS -> RESP and latch the granted request
   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = resp_if ? resp_rdata : if_rdata_q;
      d_rdata_d  = resp_d  ? resp_rdata : d_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               state_d = ST_ACCESS;
               port_d  = gnt[PORT_D];
               if (gnt[PORT_D]) begin
                  we_d    = bus.d_we;
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = bus.if_addr;
               end
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // state and latches; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         port_q     <= PORT_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         port_q     <= port_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for the two-port RAM arbiter
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   localparam int DEPTH = 10;
   localparam int WORDS = 1 << DEPTH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   ram_arbiter_if #(.DEPTH(DEPTH)) bus ();

   ram_arbiter #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   // external RAM: registered read, read register untouched on writes
   logic [31:0] ram_mem [WORDS];
   logic [31:0] ram_rd_q = '0;
   assign bus.ram_rdata = ram_rd_q;

   always @(posedge clk) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_rd_q <= ram_mem[bus.ram_addr];
   end

   // reference model and scoreboard state
   typedef struct { logic [31:0] data; int cyc; } exp_t;
   logic [31:0]      ref_mem [WORDS];
   exp_t             if_q[$];
   exp_t             d_q[$];
   int               cyc = 0;
   int               last_g = -100;
   logic             last_port = PORT_D;
   logic             acc_pend = 1'b0;
   int               acc_cyc;
   logic             acc_we;
   logic [DEPTH-1:0] acc_addr;
   logic [31:0]      acc_wdata;
   logic [31:0]      if_hold = '0;
   logic [31:0]      d_hold = '0;
   int               if_wait = 0;
   int               max_if_wait = 0;
   logic             glog[$];
   int               glog_cyc[$];

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // monitor: every cycle compare grants, RAM access and responses against the model
   initial begin
      exp_t        e;
      logic [1:0]  exp_g;
      logic [31:0] rdat;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            chk("rst_gnt",      32'({bus.d_gnt, bus.if_gnt}), 32'd0);
            chk("rst_rvalid",   32'({bus.d_rvalid, bus.if_rvalid}), 32'd0);
            chk("rst_ram_we",   32'(bus.ram_we), 32'd0);
            chk("rst_busy",     32'(busy), 32'd0);
            chk("rst_if_rdata", bus.if_rdata, 32'd0);
            chk("rst_d_rdata",  bus.d_rdata, 32'd0);
            chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
            if_q.delete();
            d_q.delete();
            glog.delete();
            glog_cyc.delete();
            last_port = PORT_D;
            last_g    = -100;
            acc_pend  = 1'b0;
            if_hold   = '0;
            d_hold    = '0;
            if_wait   = 0;
         end else begin
            if (acc_pend && cyc == acc_cyc) begin
               chk("acc_ram_we",   32'(bus.ram_we), 32'(acc_we));
               chk("acc_ram_addr", 32'(bus.ram_addr), 32'(acc_addr));
               if (acc_we) begin
                  chk("acc_ram_wdata", bus.ram_wdata, acc_wdata);
                  ref_mem[acc_addr] = acc_wdata;
               end
               acc_pend = 1'b0;
            end else begin
               chk("ram_we_idle", 32'(bus.ram_we), 32'd0);
            end

            chk("busy", 32'(busy), 32'(cyc == last_g + 1 || cyc == last_g + 2));

            if (bus.if_rvalid) begin
               if (if_q.size() == 0) begin
                  chk("if_rvalid_unexpected", 32'(bus.if_rvalid), 32'd0);
               end else begin
                  e = if_q.pop_front();
                  chk("if_rdata", bus.if_rdata, e.data);
                  chk("if_latency", 32'(cyc - e.cyc), 32'd2);
                  if_hold = e.data;
               end
            end else begin
               chk("if_rdata_hold", bus.if_rdata, if_hold);
               if (if_q.size() != 0 && cyc >= if_q[0].cyc + 2) begin
                  chk("if_rvalid_missing", 32'(bus.if_rvalid), 32'd1);
                  void'(if_q.pop_front());
               end
            end

            if (bus.d_rvalid) begin
               if (d_q.size() == 0) begin
                  chk("d_rvalid_unexpected", 32'(bus.d_rvalid), 32'd0);
               end else begin
                  e = d_q.pop_front();
                  chk("d_rdata", bus.d_rdata, e.data);
                  chk("d_latency", 32'(cyc - e.cyc), 32'd2);
                  d_hold = e.data;
               end
            end else begin
               chk("d_rdata_hold", bus.d_rdata, d_hold);
               if (d_q.size() != 0 && cyc >= d_q[0].cyc + 2) begin
                  chk("d_rvalid_missing", 32'(bus.d_rvalid), 32'd1);
                  void'(d_q.pop_front());
               end
            end

            // one transaction every three cycles at most, ties alternate
            exp_g = 2'b00;
            if (cyc >= last_g + 3) begin
               if (bus.if_req && bus.d_req) exp_g = (last_port == PORT_D) ? 2'b01 : 2'b10;
               else                         exp_g = {bus.d_req, bus.if_req};
            end
            chk("gnt", 32'({bus.d_gnt, bus.if_gnt}), 32'(exp_g));

            if (exp_g != 2'b00) begin
               acc_pend = 1'b1;
               acc_cyc  = cyc + 1;
               if (exp_g[1]) begin
                  acc_we    = bus.d_we;
                  acc_addr  = bus.d_addr;
                  acc_wdata = bus.d_wdata;
                  rdat      = bus.d_we ? 32'd0 : ref_mem[bus.d_addr];
                  d_q.push_back('{data: rdat, cyc: cyc});
                  last_port = PORT_D;
               end else begin
                  acc_we    = 1'b0;
                  acc_addr  = bus.if_addr;
                  acc_wdata = '0;
                  if_q.push_back('{data: ref_mem[bus.if_addr], cyc: cyc});
                  last_port = PORT_IF;
                  if (if_wait + 1 > max_if_wait) max_if_wait = if_wait + 1;
                  if_wait = 0;
               end
               last_g = cyc;
               glog.push_back(last_port);
               glog_cyc.push_back(cyc);
            end else if (bus.if_req) begin
               if_wait++;
            end
         end
      end
   end

   // issue one request and hold it until granted; keep leaves req high for a follow-on
   task automatic txn(input logic p, input logic we, input logic [DEPTH-1:0] addr,
                      input logic [31:0] wd, input bit keep);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      if (p == PORT_D) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = (p == PORT_D) ? bus.d_gnt : bus.if_gnt;
      end
      if (!got) chk(p ? "d_gnt_timeout" : "if_gnt_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
      if (!keep) begin
         if (p == PORT_D) bus.d_req = 1'b0;
         else             bus.if_req = 1'b0;
      end
   endtask

   task automatic rand_port(input logic p, input int n);
      int               gap;
      logic [DEPTH-1:0] a;
      logic             we;
      for (int k = 0; k < n; k++) begin
         gap = $urandom_range(0, 3);
         a   = ($urandom_range(0, 7) == 0) ? '1 : DEPTH'($urandom_range(0, 15));
         we  = (p == PORT_D) ? 1'($urandom_range(0, 1)) : 1'b0;
         txn(p, we, a, $urandom, (gap == 0) && (k != n - 1));
         repeat (gap) @(posedge clk);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      for (int i = 0; i < WORDS; i++) begin
         v = $urandom;
         ram_mem[i] <= v;
         ref_mem[i] = v;
      end
      ram_mem[4] <= 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // fetch of word 4
      txn(PORT_IF, 1'b0, 10'h004, 32'd0, 1'b0);
      repeat (3) @(posedge clk);

      // store then load of word 0x010
      txn(PORT_D, 1'b1, 10'h010, 32'h12345678, 1'b0);
      txn(PORT_D, 1'b0, 10'h010, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      chk("ram_word_0x010", ram_mem[10'h010], 32'h12345678);

      // both ports held from reset: IF, D, IF, D three cycles apart
      do_reset();
      fork
         begin
            txn(PORT_IF, 1'b0, 10'h001, 32'd0, 1'b1);
            txn(PORT_IF, 1'b0, 10'h002, 32'd0, 1'b0);
         end
         begin
            txn(PORT_D, 1'b0, 10'h003, 32'd0, 1'b1);
            txn(PORT_D, 1'b1, 10'h005, 32'hCAFE0001, 1'b0);
         end
      join
      repeat (3) @(posedge clk);
      chk("alt_count", 32'(glog.size()), 32'd4);
      for (int i = 0; i < glog.size() && i < 4; i++) begin
         chk("alt_port", 32'(glog[i]), 32'(i % 2));
         if (i > 0) chk("alt_spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd3);
      end

      // data port hammering while fetch waits
      max_if_wait = 0;
      fork
         begin
            for (int k = 0; k < 6; k++) txn(PORT_D, 1'(k % 2), DEPTH'(k + 8), 32'(k), k != 5);
         end
         begin
            repeat (2) @(posedge clk);
            txn(PORT_IF, 1'b0, 10'h009, 32'd0, 1'b0);
         end
      join
      repeat (3) @(posedge clk);
      chk("if_starvation", 32'(max_if_wait > 6), 32'd0);

      // fetch request raised during RESP of a data load
      txn(PORT_D, 1'b0, 10'h005, 32'd0, 1'b0);
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 10'h007;
      @(negedge clk);
      chk("resp_no_gnt", 32'(bus.if_gnt), 32'd0);
      @(negedge clk);
      chk("idle_gnt", 32'(bus.if_gnt), 32'd1);
      @(posedge clk); #1;
      bus.if_req = 1'b0;
      repeat (3) @(posedge clk);

      // reset in the ACCESS cycle of a store to the top word
      txn(PORT_D, 1'b1, 10'h3FF, 32'hA5A50001, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_ram_we", 32'(bus.ram_we), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_d_rvalid", 32'(bus.d_rvalid), 32'd0);
      repeat (2) @(posedge clk);
      chk("abort_ram_word", ram_mem[10'h3FF], ref_mem[10'h3FF]);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // randomized traffic on both ports
      fork
         rand_port(PORT_IF, 40);
         rand_port(PORT_D, 40);
      join
      repeat (6) @(posedge clk);
      chk("if_queue_drained", 32'(if_q.size()), 32'd0);
      chk("d_queue_drained", 32'(d_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
